// File: rtl/oam_dma_if.sv
// CPU-side and memory-map-side bus bundle for the sprite OAM DMA engine.
// Flow control: the CPU may advance a cycle only while cpu_ready is 1; there is no other handshake.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  bus_d_in;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_out;
    logic        bus_write;
    logic        dma_active;

    modport master (
        input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
        output cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
    );

    modport slave (
        output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
        input  cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to DMA_REG_ADDR stalls the CPU and copies one page
// into the PPU OAM data port, alternating read/write cycles on even/odd parity.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    oam_dma_if.master  bus,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] buf_q;
    logic       cyc_odd;
    logic       ready_q;
    logic       active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            buf_q    <= 8'h00;
            cyc_odd  <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
            case (state)
                IDLE: begin
                    if (bus.cpu_write && bus.cpu_addr == DMA_REG_ADDR) begin
                        page     <= bus.cpu_d_out;
                        idx      <= 8'h00;
                        state    <= HALT;
                        ready_q  <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                // A pending CPU write keeps us here; leaving on an odd cycle lands READ on even.
                HALT: begin
                    if (!bus.cpu_write) state <= cyc_odd ? READ : ALIGN;
                end
                ALIGN: state <= READ;
                READ: begin
                    buf_q <= bus.bus_d_in;
                    state <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        ready_q  <= 1'b1;
                        active_q <= 1'b0;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ready_q  <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Pass-through in IDLE/HALT; the DMA owns the bus from ALIGN onward.
    always_comb begin
        bus.bus_addr  = bus.cpu_addr;
        bus.bus_d_out = bus.cpu_d_out;
        bus.bus_write = bus.cpu_write;
        case (state)
            ALIGN: begin
                bus.bus_d_out = buf_q;
                bus.bus_write = 1'b0;
            end
            READ: begin
                bus.bus_addr  = {page, idx};
                bus.bus_d_out = buf_q;
                bus.bus_write = 1'b0;
            end
            WRITE: begin
                bus.bus_addr  = OAM_DATA_ADDR;
                bus.bus_d_out = buf_q;
                bus.bus_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cpu_ready  = ready_q;
    assign bus.dma_active = active_q;
    assign state_dbg      = state;
endmodule
